// File: rtl/pc_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit_if
//
// Bundles the three handshakes of the fetch stage:
//   - redirect from execute  : redirect_i, redirect_pc_i
//   - instruction memory bus : imem_req_o, imem_addr_o, imem_rvalid_i,
//                              imem_rdata_i
//   - decode hand-off        : inst_valid_o, inst_o, inst_pc_o,
//                              inst_ready_i, misalign_o
//
// Signal suffixes are written from the fetch unit's point of view.
// The master modport is taken by the fetch unit itself. The slave modport
// is taken by whatever surrounds it: memory, decode and redirect source.
// ---------------------------------------------------------------------------
interface pc_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            redirect_i;
    logic [XLEN-1:0] redirect_pc_i;

    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_rvalid_i;
    logic [31:0]     imem_rdata_i;

    logic            inst_valid_o;
    logic [31:0]     inst_o;
    logic [XLEN-1:0] inst_pc_o;
    logic            inst_ready_i;
    logic            misalign_o;

    modport master (
        input  redirect_i, redirect_pc_i, imem_rvalid_i, imem_rdata_i, inst_ready_i,
        output imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o, misalign_o
    );

    modport slave (
        output redirect_i, redirect_pc_i, imem_rvalid_i, imem_rdata_i, inst_ready_i,
        input  imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o, misalign_o
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//
// Program counter and instruction-fetch stage. The unit owns the PC and
// keeps at most one instruction-memory request outstanding. It hands each
// fetched word, together with its PC, to decode over a valid/ready
// handshake. A redirect is accepted in any cycle, including while a
// request is in flight. In that case the in-flight response is drained and
// then discarded.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    pc_fetch_unit_if.master with these groups:
//            redirect_i / redirect_pc_i        redirect request and target
//            imem_req_o / imem_addr_o          fetch request; address held
//                                              until imem_rvalid_i
//            imem_rvalid_i / imem_rdata_i      memory response
//            inst_valid_o / inst_o / inst_pc_o instruction sent to decode
//            inst_ready_i                      decode accepts the instruction
//            misalign_o                        one-cycle pulse after a
//                                              misaligned redirect
//
// Optional feature (compile-time macro PC_MISALIGN_TRAP_EN):
//   When the macro is defined, a redirect with any of its low log2(STEP)
//   bits set loads TRAP_VECTOR and pulses misalign_o.
//   When the macro is undefined, those low bits are simply cleared and
//   misalign_o stays 0.
//
// Every output comes straight from a flop, so no input reaches an output
// within the same cycle.
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              STEP         = 4,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
    input  logic            clk,
    input  logic            reset,
    pc_fetch_unit_if.master bus
);

    // STEP is a power of two, so STEP-1 selects exactly the sub-step bits.
    localparam logic [XLEN-1:0] LOW_MASK = XLEN'(STEP - 1);
    localparam logic [XLEN-1:0] STEP_INC = XLEN'(STEP);

`ifdef PC_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        BOOT,   // one idle cycle after reset before the first request
        FETCH,  // request at pc_q outstanding
        DRAIN,  // stale request outstanding at addr_q; pc_q already redirected
        HOLD    // instruction presented to decode, no request
    } state_t;

    state_t          state_q;
    logic [XLEN-1:0] pc_q;         // next address to fetch in program order
    logic [XLEN-1:0] addr_q;       // address currently driven to memory
    logic            req_q;
    logic            inst_valid_q;
    logic [31:0]     inst_q;
    logic [XLEN-1:0] inst_pc_q;
    logic            misalign_q;

    logic [XLEN-1:0] redirect_target;
    logic            redirect_trap;

    // NOTE: every signal of a combinational block is assigned on every path;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        redirect_trap   = TRAP_EN && ((bus.redirect_pc_i & LOW_MASK) != '0);
        redirect_target = redirect_trap ? TRAP_VECTOR : (bus.redirect_pc_i & ~LOW_MASK);
    end

    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // reads the values from before the edge, whatever order the branches
    // are written in.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the unit holds no memory arrays, so every register gets a
        // defined reset value. An outstanding memory response is not assumed
        // to arrive after reset.
        if (reset) begin
            state_q      <= BOOT;
            pc_q         <= RESET_VECTOR;
            addr_q       <= RESET_VECTOR;
            req_q        <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            misalign_q   <= 1'b0;
        end else begin
            misalign_q <= bus.redirect_i && redirect_trap;

            if (bus.redirect_i) begin
                // A redirect beats fetch completion and decode acceptance.
                pc_q         <= redirect_target;
                inst_valid_q <= 1'b0;
                case (state_q)
                    FETCH: begin
                        if (bus.imem_rvalid_i) begin
                            // Response lands this cycle: drop it and fetch
                            // the new target right away.
                            state_q <= FETCH;
                            addr_q  <= redirect_target;
                            req_q   <= 1'b1;
                        end else begin
                            // The request stays up at its old address until
                            // memory answers.
                            state_q <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        state_q <= DRAIN;
                    end
                    default: begin  // BOOT, HOLD
                        state_q <= FETCH;
                        addr_q  <= redirect_target;
                        req_q   <= 1'b1;
                    end
                endcase
            end else begin
                case (state_q)
                    BOOT: begin
                        state_q <= FETCH;
                        addr_q  <= pc_q;
                        req_q   <= 1'b1;
                    end
                    FETCH: begin
                        if (bus.imem_rvalid_i) begin
                            inst_q       <= bus.imem_rdata_i;
                            inst_pc_q    <= pc_q;
                            inst_valid_q <= 1'b1;
                            pc_q         <= pc_q + STEP_INC;  // wraps modulo 2^XLEN
                            req_q        <= 1'b0;
                            state_q      <= HOLD;
                        end
                    end
                    DRAIN: begin
                        if (bus.imem_rvalid_i) begin
                            // Stale data is dropped. The request stays high
                            // and moves to the redirected PC.
                            addr_q  <= pc_q;
                            state_q <= FETCH;
                        end
                    end
                    HOLD: begin
                        if (bus.inst_ready_i) begin
                            inst_valid_q <= 1'b0;
                            addr_q       <= pc_q;
                            req_q        <= 1'b1;
                            state_q      <= FETCH;
                        end
                    end
                    default: begin
                        state_q <= BOOT;
                    end
                endcase
            end
        end
    end

    assign bus.imem_req_o   = req_q;
    assign bus.imem_addr_o  = addr_q;
    assign bus.inst_valid_o = inst_valid_q;
    assign bus.inst_o       = inst_q;
    assign bus.inst_pc_o    = inst_pc_q;
    assign bus.misalign_o   = misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_unit
//
// Bench for pc_fetch_unit (XLEN=32, STEP=4, TRAP_VECTOR=0x100).
//
// The bench models memory with a variable response delay. The expected
// behaviour is written in program-order terms:
//   - fetch_pc      : address the next fresh request must carry
//   - q             : instructions owed to decode (at most one)
//   - discard       : the in-flight response is stale
//   - reissue       : the next request repeats the old address
//
// Directed steps cover the listed scenarios first. A random run then
// follows, checked against the same model.
// ---------------------------------------------------------------------------
module tb_pc_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    logic clk;
    logic reset;

    pc_fetch_unit_if #(.XLEN(32)) bus ();

    pc_fetch_unit #(
        .XLEN        (32),
        .RESET_VECTOR(32'h0000_0000),
        .STEP        (4),
        .TRAP_VECTOR (32'h0000_0100)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;

    // memory and stimulus state
    bit          nop_mode;
    int          mem_wait;      // fixed wait cycles, or -1 for random 0..3
    int          wait_cnt;
    int          cur_lat;
    bit          ready_val;
    logic        p_req;
    logic        p_rvalid;

    // reference model state
    exp_t        q[$];
    logic [31:0] fetch_pc;
    logic [31:0] cur_addr;
    bit          discard;
    bit          reissue;
    bit          boot;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return nop_mode ? 32'h0000_0013 : ((a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F);
    endfunction

    function automatic bit trap_expected(input logic [31:0] t);
`ifdef PC_MISALIGN_TRAP_EN
        return t[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] target_of(input logic [31:0] t);
        if (trap_expected(t)) return 32'h0000_0100;
        return {t[31:2], 2'b00};
    endfunction

    // One clock cycle. The task is entered just after an edge (or mid-cycle
    // after reset release). It drives inputs, checks the request side,
    // clocks the design and then updates and checks the model.
    task automatic cycle(input bit redir = 1'b0, input logic [31:0] tgt = 32'h0);
        logic        s_req;
        logic        rv;
        logic        start;
        logic        accept;

        s_req = bus.imem_req_o;
        start = s_req && (!p_req || p_rvalid);
        if (start) begin
            wait_cnt = 0;
            cur_lat  = (mem_wait >= 0) ? mem_wait : int'($urandom_range(0, 3));
        end
        rv = s_req && (wait_cnt == cur_lat);
        if (s_req) wait_cnt++;

        bus.imem_rvalid_i = rv;
        bus.imem_rdata_i  = rv ? word_at(bus.imem_addr_o) : $urandom;
        bus.redirect_i    = redir;
        bus.redirect_pc_i = tgt;
        bus.inst_ready_i  = ready_val;

        if (start) begin
            if (reissue) begin
                check("reissue_addr", bus.imem_addr_o, cur_addr);
            end else begin
                check("req_addr", bus.imem_addr_o, fetch_pc);
                cur_addr = fetch_pc;
            end
            reissue = 1'b0;
        end else if (s_req) begin
            check("addr_stable", bus.imem_addr_o, cur_addr);
        end

        accept   = (q.size() != 0) && ready_val && !redir;
        p_req    = s_req;
        p_rvalid = rv;

        @(posedge clk);
        #1;

        boot = 1'b0;
        if (accept) void'(q.pop_front());
        if (redir) begin
            fetch_pc = target_of(tgt);
            q.delete();
            if (s_req && !rv) discard = 1'b1;
            else if (s_req && rv && discard) reissue = 1'b1;
        end else if (s_req && rv) begin
            if (discard) begin
                discard = 1'b0;
            end else begin
                q.push_back('{pc: cur_addr, word: word_at(cur_addr)});
                fetch_pc = cur_addr + 32'd4;
            end
        end

        check("inst_valid", bus.inst_valid_o, (q.size() != 0));
        check("imem_req", bus.imem_req_o, (q.size() == 0) && !boot);
        if (q.size() != 0) begin
            check("inst_pc", bus.inst_pc_o, q[0].pc);
            check("inst", bus.inst_o, q[0].word);
        end
        check("misalign", bus.misalign_o, redir && trap_expected(tgt));
    endtask

    task automatic do_reset();
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = '0;
        bus.inst_ready_i  = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_req", bus.imem_req_o, 0);
        check("rst_valid", bus.inst_valid_o, 0);
        check("rst_inst", bus.inst_o, 0);
        check("rst_inst_pc", bus.inst_pc_o, 0);
        check("rst_misalign", bus.misalign_o, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset    = 1'b0;
        q.delete();
        fetch_pc = 32'h0000_0000;
        cur_addr = 32'h0000_0000;
        discard  = 1'b0;
        reissue  = 1'b0;
        boot     = 1'b1;
        p_req    = 1'b0;
        p_rvalid = 1'b0;
        wait_cnt = 0;
        cur_lat  = 0;
    endtask

    initial begin
        logic [31:0] exp_tgt;
        logic [31:0] tgt;
        int          sel;

        reset     = 1'b0;
        nop_mode  = 1'b1;
        mem_wait  = 0;
        ready_val = 1'b1;
        #2;
        do_reset();

        // Zero-wait memory, decode always ready. The first request appears
        // after the first edge.
        cycle();
        check("seq_req0", bus.imem_req_o, 1);
        check("seq_addr0", bus.imem_addr_o, 32'h0);
        cycle();
        check("seq_valid0", bus.inst_valid_o, 1);
        check("seq_pc0", bus.inst_pc_o, 32'h0);
        check("seq_inst0", bus.inst_o, 32'h0000_0013);
        cycle();
        check("seq_valid_gap", bus.inst_valid_o, 0);
        check("seq_addr4", bus.imem_addr_o, 32'h4);
        cycle();
        check("seq_pc4", bus.inst_pc_o, 32'h4);

        // Decode stalls for 5 cycles: held instruction, no request.
        ready_val = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("stall_valid", bus.inst_valid_o, 1);
            check("stall_pc", bus.inst_pc_o, 32'h4);
            check("stall_req", bus.imem_req_o, 0);
        end
        ready_val = 1'b1;
        cycle();
        check("stall_addr8", bus.imem_addr_o, 32'h8);
        cycle();
        check("stall_pc8", bus.inst_pc_o, 32'h8);

        // Redirect in HOLD with decode ready: the held instruction is dropped.
        cycle(1'b1, 32'h40);
        check("hold_redir_valid", bus.inst_valid_o, 0);
        check("hold_redir_addr", bus.imem_addr_o, 32'h40);
        cycle();
        check("hold_redir_pc", bus.inst_pc_o, 32'h40);

        // Three-cycle memory, redirect in the first wait cycle.
        mem_wait = 2;
        cycle();
        check("drain_addr_old", bus.imem_addr_o, 32'h44);
        cycle(1'b1, 32'h80);
        check("drain_hold_addr1", bus.imem_addr_o, 32'h44);
        check("drain_req1", bus.imem_req_o, 1);
        cycle();
        check("drain_hold_addr2", bus.imem_addr_o, 32'h44);
        cycle();
        check("drain_no_data", bus.inst_valid_o, 0);
        check("drain_new_addr", bus.imem_addr_o, 32'h80);
        mem_wait = 0;
        cycle();
        check("drain_pc80", bus.inst_pc_o, 32'h80);

        // Redirect to the top of the address space: the PC wraps to 0.
        cycle(1'b1, 32'hFFFF_FFFC);
        check("wrap_addr_top", bus.imem_addr_o, 32'hFFFF_FFFC);
        cycle();
        check("wrap_pc_top", bus.inst_pc_o, 32'hFFFF_FFFC);
        cycle();
        check("wrap_addr_zero", bus.imem_addr_o, 32'h0);

        // Misaligned redirect, landing on a same-cycle response.
        exp_tgt = trap_expected(32'h42) ? 32'h100 : 32'h40;
        cycle(1'b1, 32'h42);
        check("mis_addr", bus.imem_addr_o, exp_tgt);
        check("mis_pulse", bus.misalign_o, trap_expected(32'h42));
        cycle();
        check("mis_pulse_end", bus.misalign_o, 0);
        check("mis_pc", bus.inst_pc_o, exp_tgt);

        // Reset mid-operation clears everything without waiting for an edge.
        do_reset();
        nop_mode = 1'b0;
        mem_wait = -1;
        cycle();
        check("rerun_addr", bus.imem_addr_o, 32'h0);

        // Random traffic: memory delay, decode stalls and redirects.
        for (int n = 0; n < 3000; n++) begin
            ready_val = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 11) == 0) begin
                sel = int'($urandom_range(0, 9));
                if (sel == 0)      tgt = 32'hFFFF_FFFC - ($urandom_range(0, 3) * 32'd4);
                else if (sel < 3)  tgt = $urandom;
                else               tgt = 32'($urandom_range(0, 255)) << 2;
                cycle(1'b1, tgt);
            end else begin
                cycle();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
